// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, ROM address, valid/ready output slot and saturating fetch count.
// Optional FETCH_BRANCH_EN resolves unconditional br (opcode 4'b1100) in fetch.
module fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [INST_W-1:0] ir_inst,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  fetch_count
);
    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;
    state_t            r_state, w_state_n;
    logic [ADDR_W-1:0] r_pc, w_pc_n, r_ir_pc, w_ir_pc_n, w_seq_pc;
    logic [INST_W-1:0] r_ir_inst, w_ir_inst_n;
    logic              r_ir_valid, w_ir_valid_n;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_fire, w_free;
    assign w_fire = r_ir_valid & ir_ready;
    assign w_free = !r_ir_valid | ir_ready;
`ifdef FETCH_BRANCH_EN
    assign w_seq_pc = (rom_inst[INST_W-1 -: 4] == 4'b1100) ? ADDR_W'(rom_inst[11:8]) : r_pc + ADDR_W'(1);
`else
    assign w_seq_pc = r_pc + ADDR_W'(1);
`endif
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_ir_valid_n = r_ir_valid;
        w_ir_inst_n  = r_ir_inst;
        w_ir_pc_n    = r_ir_pc;
        if (stop) begin
            w_state_n    = IDLE;
            w_ir_valid_n = 1'b0;
        end else if (redirect_valid) begin
            w_pc_n       = redirect_pc;
            w_ir_valid_n = 1'b0;
            w_state_n    = (r_state == IDLE) ? IDLE : FETCH;
        end else if (r_state == IDLE) begin
            w_ir_valid_n = 1'b0;
            w_state_n    = start ? FETCH : IDLE;
        end else if (w_free) begin
            w_ir_inst_n  = rom_inst;
            w_ir_pc_n    = r_pc;
            w_ir_valid_n = 1'b1;
            w_pc_n       = w_seq_pc;
            w_state_n    = FETCH;
        end else begin
            w_state_n = STALL;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_ir_valid <= 1'b0;
            r_ir_inst  <= '0;
            r_ir_pc    <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_ir_valid <= w_ir_valid_n;
            r_ir_inst  <= w_ir_inst_n;
            r_ir_pc    <= w_ir_pc_n;
            if (w_fire && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
    assign rom_addr    = r_pc;
    assign ir_valid    = r_ir_valid;
    assign ir_inst     = r_ir_inst;
    assign ir_pc       = r_ir_pc;
    assign fetch_count = r_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; expected slot words queued from a ROM/PC model.
module tb_fetch_unit;
    logic        clk = 0, rst_n = 1, start = 0, stop = 0, ir_ready = 0;
    logic        redirect_valid = 0;
    logic [3:0]  redirect_pc = 0;
    logic [3:0]  rom_addr, ir_pc;
    logic [15:0] rom_inst, ir_inst;
    logic        ir_valid;
    logic [7:0]  fetch_count;
    logic [15:0] rom [16];
    logic [19:0] exp_q [$];
    logic [3:0]  m_pc = 0;
    int          exp_cnt = 0;
    int          checks = 0, errors = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .rom_addr(rom_addr), .rom_inst(rom_inst),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_inst(ir_inst), .ir_pc(ir_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;
    assign rom_inst = rom[rom_addr];

    function automatic logic [3:0] nxt(input logic [3:0] p, input logic [15:0] w);
`ifdef FETCH_BRANCH_EN
        return (w[15:12] == 4'hC) ? w[11:8] : p + 4'd1;
`else
        return p + 4'd1;
`endif
    endfunction

    // Fires n slot words with ready high, comparing each against the queue head.
    task automatic stream(input int n);
        int fires = 0;
        int cyc = 0;
        logic [19:0] e;
        while (exp_q.size() < n + 1) begin
            exp_q.push_back({m_pc, rom[m_pc]});
            m_pc = nxt(m_pc, rom[m_pc]);
        end
        while (fires < n && cyc < 4 * n + 10) begin
            @(negedge clk);
            cyc++;
            ir_ready = 1;
            if (ir_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({ir_pc, ir_inst} !== e) begin
                    errors++;
                    $display("FAIL stream_word got pc=%0d inst=%h want pc=%0d inst=%h", ir_pc, ir_inst, e[19:16], e[15:0]);
                end
                fires++;
                if (exp_cnt != 255) exp_cnt++;
            end
        end
        checks++;
        if (fires != n) begin
            errors++;
            $display("FAIL stream_timeout got %0d fires want %0d", fires, n);
        end
        @(negedge clk);
        ir_ready = 0;
    endtask

    task automatic test_reset;
        #1 rst_n = 0;
        #10;
        checks++;
        if (ir_valid !== 0 || rom_addr !== 0 || ir_inst !== 0 || ir_pc !== 0 || fetch_count !== 0) begin
            errors++;
            $display("FAIL reset got v=%b pc=%0d inst=%h irpc=%0d cnt=%0d want all 0", ir_valid, rom_addr, ir_inst, ir_pc, fetch_count);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (ir_valid !== 0) begin
            errors++;
            $display("FAIL idle_valid got %b want 0", ir_valid);
        end
    endtask

    task automatic test_stream;
        m_pc = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (ir_valid !== 0) begin
            errors++;
            $display("FAIL start_latency got v=%b want 0", ir_valid);
        end
        stream(3);
        checks++;
        if (fetch_count !== 8'd3) begin
            errors++;
            $display("FAIL stream_count got %0d want 3", fetch_count);
        end
    endtask

    task automatic test_stall;
        logic [19:0] e;
        e = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ir_valid !== 1 || {ir_pc, ir_inst} !== e || fetch_count !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL stall got v=%b pc=%0d inst=%h cnt=%0d want v=1 pc=%0d inst=%h cnt=%0d",
                         ir_valid, ir_pc, ir_inst, fetch_count, e[19:16], e[15:0], exp_cnt);
            end
        end
    endtask

    task automatic test_branch;
        logic [3:0] want;
`ifdef FETCH_BRANCH_EN
        want = 4'd15;
`else
        want = 4'd4;
`endif
        stream(1);
        checks++;
        if (ir_valid !== 1 || ir_pc !== want) begin
            errors++;
            $display("FAIL branch_next got v=%b pc=%0d want v=1 pc=%0d", ir_valid, ir_pc, want);
        end
    endtask

    task automatic test_redirect;
        logic [19:0] e;
        @(negedge clk);
        ir_ready = 1;
        redirect_valid = 1;
        redirect_pc = 4'd9;
        e = exp_q.pop_front();
        checks++;
        if (ir_valid !== 1 || {ir_pc, ir_inst} !== e) begin
            errors++;
            $display("FAIL redirect_slot got v=%b pc=%0d inst=%h want pc=%0d inst=%h", ir_valid, ir_pc, ir_inst, e[19:16], e[15:0]);
        end
        if (exp_cnt != 255) exp_cnt++;
        @(negedge clk);
        redirect_valid = 0;
        ir_ready = 0;
        checks++;
        if (ir_valid !== 0 || fetch_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL redirect_flush got v=%b cnt=%0d want v=0 cnt=%0d", ir_valid, fetch_count, exp_cnt);
        end
        exp_q.delete();
        m_pc = 4'd9;
        @(negedge clk);
        checks++;
        if (ir_valid !== 1 || ir_pc !== 4'd9 || ir_inst !== rom[9]) begin
            errors++;
            $display("FAIL redirect_target got v=%b pc=%0d inst=%h want v=1 pc=9 inst=%h", ir_valid, ir_pc, ir_inst, rom[9]);
        end
        exp_q.push_back({m_pc, rom[m_pc]});
        m_pc = nxt(m_pc, rom[m_pc]);
    endtask

    task automatic test_wrap_saturate;
        stream(300);
        checks++;
        if (fetch_count !== 8'd255 || exp_cnt != 255) begin
            errors++;
            $display("FAIL saturate got %0d want 255 (model %0d)", fetch_count, exp_cnt);
        end
    endtask

    task automatic test_stop;
        logic [19:0] e;
        logic [3:0]  rp;
        e = exp_q[0];
        rp = nxt(e[19:16], e[15:0]);
        @(negedge clk);
        stop = 1;
        @(negedge clk);
        stop = 0;
        checks++;
        if (ir_valid !== 0 || rom_addr !== rp || fetch_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL stop got v=%b pc=%0d cnt=%0d want v=0 pc=%0d cnt=%0d", ir_valid, rom_addr, fetch_count, rp, exp_cnt);
        end
        ir_ready = 1;
        @(negedge clk);
        checks++;
        if (ir_valid !== 0 || rom_addr !== rp) begin
            errors++;
            $display("FAIL stop_idle got v=%b pc=%0d want v=0 pc=%0d", ir_valid, rom_addr, rp);
        end
        ir_ready = 0;
        exp_q.delete();
        m_pc = rp;
        start = 1;
        @(negedge clk);
        start = 0;
        stream(2);
    endtask

    task automatic test_reset_mid;
        checks++;
        if (ir_valid !== 1) begin
            errors++;
            $display("FAIL pre_reset_valid got %b want 1", ir_valid);
        end
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (ir_valid !== 0 || rom_addr !== 0 || fetch_count !== 0 || ir_pc !== 0) begin
            errors++;
            $display("FAIL async_reset got v=%b pc=%0d cnt=%0d irpc=%0d want all 0", ir_valid, rom_addr, fetch_count, ir_pc);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = {4'h2, 4'(i), 8'h5A};
        rom[0] = 16'h1E09;
        rom[1] = 16'h100A;
        rom[2] = 16'hF000;
        rom[3] = 16'hCF00;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_redirect();
        test_wrap_saturate();
        test_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
